player_sprite_renderer: RTL and testbench

Reader side of the player sprite ROM. Converts the VGA scan position and the player's on-screen position into sprite-local row/col addresses for the ROM, waits out the ROM's one-cycle registered latency, and composites the returned 12-bit colour over the background pixel. Also applies transparency, horizontal mirroring and hit-blink. Sits between the VGA timing generator / game logic and the final RGB output register.

---
 rtl/player_sprite_renderer_pkg.sv | 22 ++
 rtl/sprite_blink_ctrl.sv | 40 ++++
 rtl/player_sprite_renderer.sv | 134 +++++++++++++
 tb/tb_player_sprite_renderer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_renderer_pkg.sv
// Shared types and constants for the player sprite path.
// Sprite geometry, colour type and screen extents.
package player_sprite_renderer_pkg;

   localparam int SPRITE_W = 32;
   localparam int SPRITE_H = 48;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [11:0] color_t;

   localparam color_t TRANSPARENT = 12'hF0F;

   typedef struct packed {
      logic   in_box;
      logic   hidden;
      logic   video_on;
      color_t bg;
   } pix_side_t;

endpackage

// File: rtl/sprite_blink_ctrl.sv
// Post-hit blink timer and free-running frame counter.
// hidden is high on the "off" half of each 8-frame blink period.
module sprite_blink_ctrl #(
   parameter int BLINK_FRAMES = 60
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start,
   input  logic hit,
   output logic hidden
);

   localparam int BW = $clog2(BLINK_FRAMES + 1);

   logic [BW-1:0] blink;
   logic [2:0]    frame_cnt;

   // hit reloads the timer and wins over a same-cycle frame decrement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink <= '0;
      end else if (hit) begin
         blink <= BW'(BLINK_FRAMES);
      end else if (frame_start && (blink != '0)) begin
         blink <= blink - BW'(1);
      end
   end

   // frame counter runs freely; only bit 2 sets the blink phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 3'd1;
      end
   end

   assign hidden = (blink != '0) && frame_cnt[2];

endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite reader: box test, ROM addressing and compositing.
// Three-stage pipeline matched to the ROM's one-cycle read latency.
module player_sprite_renderer
   import player_sprite_renderer_pkg::*;
#(
   parameter int     SPRITE_W     = player_sprite_renderer_pkg::SPRITE_W,
   parameter int     SPRITE_H     = player_sprite_renderer_pkg::SPRITE_H,
   parameter color_t TRANSPARENT  = player_sprite_renderer_pkg::TRANSPARENT,
   parameter int     BLINK_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        frame_start,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   input  logic        facing_left,
   input  logic        hit,
   input  logic [11:0] bg_rgb,
   output logic [9:0]  rom_row,
   output logic [9:0]  rom_col,
   input  logic [11:0] rom_color,
   output logic [11:0] rgb,
   output logic        sprite_hit
);

   localparam logic [10:0] W11 = 11'(SPRITE_W);
   localparam logic [10:0] H11 = 11'(SPRITE_H);
   localparam logic [9:0]  WM1 = 10'(SPRITE_W - 1);

   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       facing;
   logic       hidden;

   logic [10:0] x11, y11, px11, py11;
   logic        in_box;
   logic [9:0]  dx, dy;
   logic [9:0]  row_n, col_n;

   pix_side_t side_n, side_d1, side_d2;

   sprite_blink_ctrl #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_start(frame_start),
      .hit        (hit),
      .hidden     (hidden)
   );

   // position only moves at vblank so a frame never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x  <= '0;
         pos_y  <= '0;
         facing <= 1'b0;
      end else if (frame_start) begin
         pos_x  <= player_x;
         pos_y  <= player_y;
         facing <= facing_left;
      end
   end

   assign x11  = {1'b0, pixel_x};
   assign y11  = {1'b0, pixel_y};
   assign px11 = {1'b0, pos_x};
   assign py11 = {1'b0, pos_y};

   assign in_box = (x11 >= px11) && (x11 < px11 + W11) &&
                   (y11 >= py11) && (y11 < py11 + H11);

   assign dx = pixel_x - pos_x;
   assign dy = pixel_y - pos_y;

   // sprite-local address, mirrored when facing left, zero off-sprite
   always_comb begin
      row_n = '0;
      col_n = '0;
      if (in_box) begin
         row_n = dy;
         col_n = facing ? (WM1 - dx) : dx;
      end
   end

   assign side_n = '{in_box:   in_box,
                     hidden:   hidden,
                     video_on: video_on,
                     bg:       bg_rgb};

   // stage 1: ROM address and pixel sideband
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_row <= '0;
         rom_col <= '0;
         side_d1 <= '0;
      end else begin
         rom_row <= row_n;
         rom_col <= col_n;
         side_d1 <= side_n;
      end
   end

   // stage 2: sideband waits while the ROM reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         side_d2 <= '0;
      end else begin
         side_d2 <= side_d1;
      end
   end

   // stage 3: blank, sprite or background
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb        <= '0;
         sprite_hit <= 1'b0;
      end else if (!side_d2.video_on) begin
         rgb        <= '0;
         sprite_hit <= 1'b0;
      end else if (side_d2.in_box && !side_d2.hidden &&
                   (rom_color != TRANSPARENT)) begin
         rgb        <= rom_color;
         sprite_hit <= 1'b1;
      end else begin
         rgb        <= side_d2.bg;
         sprite_hit <= 1'b0;
      end
   end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Directed bench for player_sprite_renderer.
// ROM is modelled as a registered constant colour source.
module tb_player_sprite_renderer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_on;
   logic        frame_start;
   logic [9:0]  player_x, player_y;
   logic        facing_left;
   logic        hit;
   logic [11:0] bg_rgb;
   logic [9:0]  rom_row, rom_col;
   logic [11:0] rom_color;
   logic [11:0] rgb;
   logic        sprite_hit;

   logic [11:0] rom_fill;

   int total  = 0;
   int passed = 0;

   player_sprite_renderer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .video_on   (video_on),
      .frame_start(frame_start),
      .player_x   (player_x),
      .player_y   (player_y),
      .facing_left(facing_left),
      .hit        (hit),
      .bg_rgb     (bg_rgb),
      .rom_row    (rom_row),
      .rom_col    (rom_col),
      .rom_color  (rom_color),
      .rgb        (rgb),
      .sprite_hit (sprite_hit)
   );

   always #5 clk = ~clk;

   // one-cycle registered ROM
   always @(posedge clk) rom_color <= rom_fill;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_pos(input int x, input int y, input logic f);
      player_x    = 10'(x);
      player_y    = 10'(y);
      facing_left = f;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pixel_x     = 10'($urandom);
         pixel_y     = 10'($urandom);
         video_on    = 1'($urandom);
         frame_start = 1'($urandom);
         player_x    = 10'($urandom);
         player_y    = 10'($urandom);
         facing_left = 1'($urandom);
         hit         = 1'($urandom);
         bg_rgb      = 12'($urandom);
         rom_fill    = 12'($urandom);
         tick();
         total++;
         if ({rgb, sprite_hit, rom_row, rom_col} !== 33'd0)
            $display("FAIL reset_outs cyc %0d got rgb=%h hit=%b row=%0d col=%0d want all 0",
                     i, rgb, sprite_hit, rom_row, rom_col);
         else passed++;
      end
      pixel_x = 0; pixel_y = 0; video_on = 0; frame_start = 0;
      player_x = 0; player_y = 0; facing_left = 0; hit = 0;
      bg_rgb = 0; rom_fill = 0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      set_pos(100, 200, 1'b0);
      rom_fill = 12'h0F0;
      bg_rgb   = 12'h123;
      video_on = 1'b1;
      pixel_x  = 10'd105;
      pixel_y  = 10'd210;
      tick();
      total++;
      if (rom_col !== 10'd5 || rom_row !== 10'd10)
         $display("FAIL basic_addr got col=%0d row=%0d want col=5 row=10", rom_col, rom_row);
      else passed++;
      pixel_x = 10'd0;
      pixel_y = 10'd0;
      bg_rgb  = 12'h456;
      tick();
      total++;
      if (sprite_hit !== 1'b0)
         $display("FAIL basic_early got hit=%b want 0", sprite_hit);
      else passed++;
      tick();
      total++;
      if (rgb !== 12'h0F0 || sprite_hit !== 1'b1)
         $display("FAIL basic_rgb got rgb=%h hit=%b want 0f0/1", rgb, sprite_hit);
      else passed++;
      tick();
      total++;
      if (rgb !== 12'h456 || sprite_hit !== 1'b0)
         $display("FAIL basic_bg got rgb=%h hit=%b want 456/0", rgb, sprite_hit);
      else passed++;
   endtask

   task automatic test_mirror;
      set_pos(100, 200, 1'b1);
      rom_fill = 12'h0F0;
      bg_rgb   = 12'h123;
      pixel_x  = 10'd105;
      pixel_y  = 10'd210;
      tick();
      total++;
      if (rom_col !== 10'd26 || rom_row !== 10'd10)
         $display("FAIL mirror_addr got col=%0d row=%0d want col=26 row=10", rom_col, rom_row);
      else passed++;
      tick();
      tick();
      total++;
      if (rgb !== 12'h0F0 || sprite_hit !== 1'b1)
         $display("FAIL mirror_rgb got rgb=%h hit=%b want 0f0/1", rgb, sprite_hit);
      else passed++;
      rom_fill = 12'hF0F;
      tick();
      tick();
      tick();
      total++;
      if (rgb !== 12'h123 || sprite_hit !== 1'b0)
         $display("FAIL transparent got rgb=%h hit=%b want 123/0", rgb, sprite_hit);
      else passed++;
      set_pos(100, 200, 1'b0);
   endtask

   task automatic test_clip;
      rom_fill = 12'h0F0;
      bg_rgb   = 12'h222;
      set_pos(630, 0, 1'b0);
      pixel_x = 10'd639;
      pixel_y = 10'd5;
      tick();
      total++;
      if (rom_col !== 10'd9 || rom_row !== 10'd5)
         $display("FAIL clip_addr got col=%0d row=%0d want col=9 row=5", rom_col, rom_row);
      else passed++;
      tick();
      tick();
      total++;
      if (rgb !== 12'h0F0 || sprite_hit !== 1'b1)
         $display("FAIL clip_rgb got rgb=%h hit=%b want 0f0/1", rgb, sprite_hit);
      else passed++;
      for (int x = 0; x <= 21; x++) begin
         pixel_x = 10'(x);
         tick();
         total++;
         if (rom_col !== 10'd0 || rom_row !== 10'd0)
            $display("FAIL clip_wrap x=%0d got col=%0d row=%0d want 0/0", x, rom_col, rom_row);
         else passed++;
      end
      tick();
      tick();
      total++;
      if (sprite_hit !== 1'b0 || rgb !== 12'h222)
         $display("FAIL clip_nohit got rgb=%h hit=%b want 222/0", rgb, sprite_hit);
      else passed++;
      pixel_x = 10'd661;
      pixel_y = 10'd47;
      tick();
      total++;
      if (rom_col !== 10'd31 || rom_row !== 10'd47)
         $display("FAIL clip_edge got col=%0d row=%0d want 31/47", rom_col, rom_row);
      else passed++;
      pixel_x = 10'd662;
      tick();
      total++;
      if (rom_col !== 10'd0 || rom_row !== 10'd0)
         $display("FAIL clip_right got col=%0d row=%0d want 0/0", rom_col, rom_row);
      else passed++;
      pixel_x = 10'd661;
      pixel_y = 10'd48;
      tick();
      total++;
      if (rom_col !== 10'd0 || rom_row !== 10'd0)
         $display("FAIL clip_bottom got col=%0d row=%0d want 0/0", rom_col, rom_row);
      else passed++;
      set_pos(1000, 0, 1'b0);
      pixel_x = 10'd1010;
      pixel_y = 10'd5;
      tick();
      total++;
      if (rom_col !== 10'd10 || rom_row !== 10'd5)
         $display("FAIL clip_wide got col=%0d row=%0d want 10/5", rom_col, rom_row);
      else passed++;
      tick();
      tick();
      total++;
      if (sprite_hit !== 1'b1)
         $display("FAIL clip_wide_hit got hit=%b want 1", sprite_hit);
      else passed++;
   endtask

   task automatic test_tear;
      set_pos(100, 200, 1'b0);
      player_x = 10'd300;
      pixel_x  = 10'd105;
      pixel_y  = 10'd210;
      tick();
      total++;
      if (rom_col !== 10'd5)
         $display("FAIL tear_old got col=%0d want 5", rom_col);
      else passed++;
      pixel_x = 10'd305;
      tick();
      total++;
      if (rom_col !== 10'd0 || rom_row !== 10'd0)
         $display("FAIL tear_new_early got col=%0d row=%0d want 0/0", rom_col, rom_row);
      else passed++;
      pixel_x     = 10'd105;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      total++;
      if (rom_col !== 10'd5)
         $display("FAIL tear_same_cycle got col=%0d want 5", rom_col);
      else passed++;
      pixel_x = 10'd305;
      tick();
      total++;
      if (rom_col !== 10'd5 || rom_row !== 10'd10)
         $display("FAIL tear_latched got col=%0d row=%0d want 5/10", rom_col, rom_row);
      else passed++;
   endtask

   task automatic test_midreset;
      set_pos(100, 200, 1'b0);
      rom_fill = 12'h0F0;
      bg_rgb   = 12'h123;
      video_on = 1'b1;
      pixel_x  = 10'd105;
      pixel_y  = 10'd210;
      tick();
      tick();
      tick();
      total++;
      if (rgb !== 12'h0F0 || sprite_hit !== 1'b1)
         $display("FAIL midrst_pre got rgb=%h hit=%b want 0f0/1", rgb, sprite_hit);
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({rgb, sprite_hit, rom_row, rom_col} !== 33'd0)
         $display("FAIL midrst_clear got rgb=%h hit=%b row=%0d col=%0d want all 0",
                  rgb, sprite_hit, rom_row, rom_col);
      else passed++;
      tick();
      rst_n   = 1'b1;
      pixel_x = 10'd5;
      pixel_y = 10'd10;
      tick();
      total++;
      if (rom_col !== 10'd5 || rom_row !== 10'd10 || rgb !== 12'h000)
         $display("FAIL midrst_s1 got col=%0d row=%0d rgb=%h want 5/10/000",
                  rom_col, rom_row, rgb);
      else passed++;
      tick();
      total++;
      if (rgb !== 12'h000)
         $display("FAIL midrst_s2 got rgb=%h want 000", rgb);
      else passed++;
      tick();
      total++;
      if (rgb !== 12'h0F0 || sprite_hit !== 1'b1)
         $display("FAIL midrst_first got rgb=%h hit=%b want 0f0/1", rgb, sprite_hit);
      else passed++;
   endtask

   task automatic test_blink;
      int  blink_m;
      int  fc_m;
      logic exp_hit;
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      blink_m  = 0;
      fc_m     = 0;
      rom_fill = 12'h0F0;
      bg_rgb   = 12'h123;
      video_on = 1'b1;
      player_x = 10'd100;
      player_y = 10'd200;
      facing_left = 1'b0;
      pixel_x  = 10'd105;
      pixel_y  = 10'd210;
      for (int i = 0; i < 80; i++) begin
         frame_start = 1'b1;
         hit         = (i == 16);
         tick();
         frame_start = 1'b0;
         hit         = 1'b0;
         if (i == 16) blink_m = 60;
         else if (blink_m != 0) blink_m--;
         fc_m++;
         if (i == 2) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            blink_m = 60;
         end
         tick();
         tick();
         tick();
         exp_hit = !((blink_m != 0) && (((fc_m >> 2) & 1) == 1));
         total++;
         if (sprite_hit !== exp_hit || rgb !== (exp_hit ? 12'h0F0 : 12'h123))
            $display("FAIL blink frame=%0d got hit=%b rgb=%h want hit=%b", i,
                     sprite_hit, rgb, exp_hit);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mirror();
      test_clip();
      test_tear();
      test_midreset();
      test_blink();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
